// File: rtl/wm_pkg.sv
// Shared washing-machine types: state encoding, default phase lengths,
// and the state-to-duration mapping.
package wm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    FILL  = 3'd2,
    HEAT  = 3'd3,
    WASH  = 3'd4,
    RINSE = 3'd5,
    SPIN  = 3'd6,
    FAULT = 3'd7
  } wm_state_t;

  localparam int unsigned DEF_FILL_CYCLES  = 8;
  localparam int unsigned DEF_HEAT_CYCLES  = 8;
  localparam int unsigned DEF_WASH_CYCLES  = 16;
  localparam int unsigned DEF_RINSE_CYCLES = 12;
  localparam int unsigned DEF_SPIN_CYCLES  = 10;

  // Non-timed states report a duration of 1 so the terminal compare stays defined.
  function automatic int unsigned phase_duration(
    input wm_state_t   st,
    input int unsigned fill_d,
    input int unsigned heat_d,
    input int unsigned wash_d,
    input int unsigned rinse_d,
    input int unsigned spin_d
  );
    int unsigned d;
    d = 1;
    case (st)
      FILL:    d = fill_d;
      HEAT:    d = heat_d;
      WASH:    d = wash_d;
      RINSE:   d = rinse_d;
      SPIN:    d = spin_d;
      default: d = 1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// Phase elapsed-clock counter with clear, hold and terminal-count detect.
module wm_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             hold,
  input  logic [CNT_W-1:0] duration,
  output logic [CNT_W-1:0] phase_count,
  output logic             phase_end
);

  assign phase_end = (phase_count == duration - CNT_W'(1));

  // Count up each clock, wrap to zero at the phase's last clock.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      phase_count <= '0;
    end else if (hold) begin
      phase_count <= phase_count;
    end else if (phase_end) begin
      phase_count <= '0;
    end else begin
      phase_count <= phase_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wm_cycle_sequencer.sv
// Washing-machine cycle sequencer: FSM, rinse pass tracking and registered outputs.
module wm_cycle_sequencer
  import wm_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int FILL_CYCLES  = DEF_FILL_CYCLES,
  parameter int HEAT_CYCLES  = DEF_HEAT_CYCLES,
  parameter int WASH_CYCLES  = DEF_WASH_CYCLES,
  parameter int RINSE_CYCLES = DEF_RINSE_CYCLES,
  parameter int SPIN_CYCLES  = DEF_SPIN_CYCLES,
  parameter int NUM_RINSE    = 2,
  parameter int RINSE_W      = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sig_Lid_Closed,
  input  logic               sig_Coin,
  input  logic               sig_Cancel,
  input  logic               sig_Out_Of_Balance,
  input  logic               sig_Motor_Failure,
  input  logic               sig_Fault_Clear,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   phase_Count,
  output logic [RINSE_W-1:0] rinse_Index,
  output logic               paused,
  output logic               water_Intake,
  output logic               fault,
  output logic               coin_Return,
  output logic               cycle_Done
);

  if ((FILL_CYCLES < 1) || (FILL_CYCLES >= 2**CNT_W) ||
      (HEAT_CYCLES < 1) || (HEAT_CYCLES >= 2**CNT_W) ||
      (WASH_CYCLES < 1) || (WASH_CYCLES >= 2**CNT_W) ||
      (RINSE_CYCLES < 1) || (RINSE_CYCLES >= 2**CNT_W) ||
      (SPIN_CYCLES < 1) || (SPIN_CYCLES >= 2**CNT_W)) begin : g_bad_duration
    $error("wm_cycle_sequencer: phase duration out of range");
  end
  if ((NUM_RINSE < 1) || (NUM_RINSE >= 2**RINSE_W)) begin : g_bad_rinse
    $error("wm_cycle_sequencer: NUM_RINSE out of range");
  end

  wm_state_t            state_q, state_n;
  logic [RINSE_W-1:0]   rinse_n;
  logic [CNT_W-1:0]     cur_dur;
  logic                 tmr_clear, tmr_hold, phase_end;
  logic                 paused_n, coin_n, done_n;

  assign state   = state_q;
  assign cur_dur = CNT_W'(phase_duration(state_q, FILL_CYCLES, HEAT_CYCLES,
                                         WASH_CYCLES, RINSE_CYCLES, SPIN_CYCLES));

  wm_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock       (clock),
    .reset       (reset),
    .clear       (tmr_clear),
    .hold        (tmr_hold),
    .duration    (cur_dur),
    .phase_count (phase_Count),
    .phase_end   (phase_end)
  );

  // State, rinse pass and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      rinse_Index  <= '0;
      paused       <= 1'b0;
      water_Intake <= 1'b0;
      fault        <= 1'b0;
      coin_Return  <= 1'b0;
      cycle_Done   <= 1'b0;
    end else begin
      state_q      <= state_n;
      rinse_Index  <= rinse_n;
      paused       <= paused_n;
      water_Intake <= (state_n == FILL) && !paused_n;
      fault        <= (state_n == FAULT);
      coin_Return  <= coin_n;
      cycle_Done   <= done_n;
    end
  end

  // Next state, timer control and pulse decisions; rinse index is nonzero only inside RINSE.
  always_comb begin
    state_n   = state_q;
    rinse_n   = '0;
    tmr_clear = 1'b0;
    tmr_hold  = 1'b0;
    paused_n  = 1'b0;
    coin_n    = 1'b0;
    done_n    = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_clear = 1'b1;
        if (sig_Coin) state_n = READY;
      end
      READY: begin
        tmr_clear = 1'b1;
        if (sig_Cancel) begin
          state_n = IDLE;
          coin_n  = 1'b1;
        end else if (sig_Lid_Closed) begin
          state_n = FILL;
        end
      end
      FAULT: begin
        tmr_clear = 1'b1;
        if (sig_Fault_Clear && !sig_Lid_Closed && !sig_Motor_Failure) begin
          state_n = IDLE;
          coin_n  = 1'b1;
        end
      end
      default: begin
        if (sig_Motor_Failure && (state_q inside {WASH, RINSE, SPIN})) begin
          state_n   = FAULT;
          tmr_clear = 1'b1;
        end else if (sig_Cancel && (state_q != SPIN)) begin
          state_n   = SPIN;
          tmr_clear = 1'b1;
        end else if (!sig_Lid_Closed || (sig_Out_Of_Balance && (state_q == SPIN))) begin
          tmr_hold = 1'b1;
          paused_n = 1'b1;
          rinse_n  = rinse_Index;
        end else if (phase_end) begin
          case (state_q)
            FILL:  state_n = HEAT;
            HEAT:  state_n = WASH;
            WASH:  state_n = RINSE;
            RINSE: begin
              if (rinse_Index == RINSE_W'(NUM_RINSE - 1)) state_n = SPIN;
              else rinse_n = rinse_Index + RINSE_W'(1);
            end
            default: begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          endcase
        end else begin
          rinse_n = rinse_Index;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_wm_cycle_sequencer.sv
// Self-checking bench for wm_cycle_sequencer: vector table, directed corner
// sequences and randomized stimulus against a behavioural model.
module tb_wm_cycle_sequencer;

  localparam int CNT_W     = 16;
  localparam int RINSE_W   = 4;
  localparam int NUM_RINSE = 2;

  logic clock = 1'b0;
  logic reset, lid, coin, cancel, oob, mf, fc;
  logic [2:0]         state;
  logic [CNT_W-1:0]   phase_count;
  logic [RINSE_W-1:0] rinse_index;
  logic paused, water, fault, coin_ret, done;

  int checks = 0;
  int errors = 0;

  // Model state
  int m_st = 0, m_cnt = 0, m_ridx = 0;
  int m_paused = 0, m_water = 0, m_fault = 0, m_coin = 0, m_done = 0;

  always #5 clock = ~clock;

  wm_cycle_sequencer #(
    .CNT_W(CNT_W), .FILL_CYCLES(8), .HEAT_CYCLES(8), .WASH_CYCLES(16),
    .RINSE_CYCLES(12), .SPIN_CYCLES(10), .NUM_RINSE(NUM_RINSE), .RINSE_W(RINSE_W)
  ) dut (
    .clock(clock), .reset(reset), .sig_Lid_Closed(lid), .sig_Coin(coin),
    .sig_Cancel(cancel), .sig_Out_Of_Balance(oob), .sig_Motor_Failure(mf),
    .sig_Fault_Clear(fc), .state(state), .phase_Count(phase_count),
    .rinse_Index(rinse_index), .paused(paused), .water_Intake(water),
    .fault(fault), .coin_Return(coin_ret), .cycle_Done(done)
  );

  function automatic int dur_of(input int st);
    case (st)
      2: return 8;
      3: return 8;
      4: return 16;
      5: return 12;
      6: return 10;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Phases run in numeric order FILL(2)..SPIN(6); rinse repeats NUM_RINSE times.
  task automatic model_edge();
    m_coin = 0; m_done = 0; m_paused = 0;
    if (reset) begin
      m_st = 0; m_cnt = 0; m_ridx = 0;
    end else if (m_st == 0) begin
      if (coin) m_st = 1;
    end else if (m_st == 1) begin
      if (cancel) begin m_st = 0; m_coin = 1; end
      else if (lid) begin m_st = 2; m_cnt = 0; end
    end else if (m_st == 7) begin
      m_cnt = 0;
      if (fc && !lid && !mf) begin m_st = 0; m_coin = 1; end
    end else begin
      if (mf && m_st >= 4) begin
        m_st = 7; m_cnt = 0; m_ridx = 0;
      end else if (cancel && m_st != 6) begin
        m_st = 6; m_cnt = 0; m_ridx = 0;
      end else if (!lid || (oob && m_st == 6)) begin
        m_paused = 1;
      end else if (m_cnt + 1 == dur_of(m_st)) begin
        m_cnt = 0;
        if (m_st == 5 && m_ridx + 1 < NUM_RINSE) m_ridx++;
        else begin
          m_ridx = 0;
          if (m_st == 6) begin m_st = 0; m_done = 1; end
          else m_st++;
        end
      end else begin
        m_cnt++;
      end
    end
    m_water = (m_st == 2 && !m_paused) ? 1 : 0;
    m_fault = (m_st == 7) ? 1 : 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check("state", int'(state), m_st);
    check("phase_count", int'(phase_count), m_cnt);
    check("rinse_index", int'(rinse_index), m_ridx);
    check("paused", int'(paused), m_paused);
    check("water", int'(water), m_water);
    check("fault", int'(fault), m_fault);
    check("coin_return", int'(coin_ret), m_coin);
    check("cycle_done", int'(done), m_done);
  endtask

  task automatic idle_inputs();
    reset = 0; lid = 1; coin = 0; cancel = 0; oob = 0; mf = 0; fc = 0;
  endtask

  task automatic start_run();
    idle_inputs(); reset = 1; step();
    reset = 0; coin = 1; step();
    coin = 0; step();
  endtask

  task automatic run_until(input int st, input int cnt, input int ridx, input int budget);
    int n = 0;
    while (!(m_st == st && m_cnt == cnt && m_ridx == ridx) && n < budget) begin
      step(); n++;
    end
    if (!(m_st == st && m_cnt == cnt && m_ridx == ridx)) begin
      checks++; errors++;
      $display("FAIL run_until timeout: state %0d cnt %0d required %0d %0d", m_st, m_cnt, st, cnt);
    end
  endtask

  typedef struct {
    logic rst, cn, ld, cc, ob, mfl, fcl;
    int st, cnt, pz, cr, flt;
  } vec_t;

  function automatic vec_t mk(input logic rst, cn, ld, cc, ob, mfl, fcl,
                              input int st, cnt, pz, cr, flt);
    vec_t v;
    v.rst = rst; v.cn = cn; v.ld = ld; v.cc = cc; v.ob = ob; v.mfl = mfl; v.fcl = fcl;
    v.st = st; v.cnt = cnt; v.pz = pz; v.cr = cr; v.flt = flt;
    return v;
  endfunction

  initial begin
    vec_t tbl[18];
    int occ[8];
    int occ_r[2];
    int n, done_at, done_cnt, cr_seen;

    //            rst cn ld cc ob mf fc   st cnt pz cr flt
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 1, 1, 0, 0, 0,   0, 0, 0, 1, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 1, 0, 0, 0, 0,   2, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 0, 0, 0, 0,   2, 1, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0,   2, 1, 1, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0, 0, 0, 0,   2, 2, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 0, 0, 1, 0,   2, 3, 0, 0, 0);
    tbl[10] = mk(0, 0, 1, 1, 0, 0, 0,   6, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 1, 1, 0, 0, 0,   6, 1, 0, 0, 0);
    tbl[12] = mk(0, 0, 1, 0, 1, 0, 0,   6, 1, 1, 0, 0);
    tbl[13] = mk(0, 0, 1, 0, 0, 1, 0,   7, 0, 0, 0, 1);
    tbl[14] = mk(0, 0, 1, 0, 0, 0, 1,   7, 0, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 1,   7, 0, 0, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0);
    tbl[17] = mk(0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);

    idle_inputs();
    for (int i = 0; i < 18; i++) begin
      reset = tbl[i].rst; coin = tbl[i].cn; lid = tbl[i].ld; cancel = tbl[i].cc;
      oob = tbl[i].ob; mf = tbl[i].mfl; fc = tbl[i].fcl;
      step();
      check($sformatf("tbl%0d_state", i), int'(state), tbl[i].st);
      check($sformatf("tbl%0d_count", i), int'(phase_count), tbl[i].cnt);
      check($sformatf("tbl%0d_paused", i), int'(paused), tbl[i].pz);
      check($sformatf("tbl%0d_coin_return", i), int'(coin_ret), tbl[i].cr);
      check($sformatf("tbl%0d_fault", i), int'(fault), tbl[i].flt);
    end

    // Normal run: phase occupancy and completion latency from FILL entry.
    start_run();
    for (int i = 0; i < 8; i++) occ[i] = 0;
    occ_r[0] = 0; occ_r[1] = 0;
    n = 0; done_at = -1; done_cnt = 0;
    occ[state]++;
    while (state != 3'd0 && n < 80) begin
      step(); n++;
      occ[state]++;
      if (state == 3'd5 && rinse_index < 2) occ_r[rinse_index]++;
      if (done) begin done_cnt++; done_at = n; end
    end
    check("run_fill", occ[2], 8);
    check("run_heat", occ[3], 8);
    check("run_wash", occ[4], 16);
    check("run_rinse0", occ_r[0], 12);
    check("run_rinse1", occ_r[1], 12);
    check("run_spin", occ[6], 10);
    check("run_done_at", done_at, 66);
    check("run_done_cnt", done_cnt, 1);
    step();
    check("run_done_pulse_end", int'(done), 0);

    // Lid-open pause in WASH at count 7.
    start_run();
    run_until(4, 7, 0, 100);
    lid = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("pause_paused", int'(paused), 1);
      check("pause_count", int'(phase_count), 7);
      check("pause_state", int'(state), 4);
    end
    lid = 1; n = 0;
    while (state == 3'd4 && n < 40) begin step(); n++; end
    check("pause_resume_steps", n, 9);
    check("pause_next_state", int'(state), 5);

    // Cancel in HEAT drains via SPIN without coin return.
    start_run();
    run_until(3, 2, 0, 100);
    cancel = 1; step(); cancel = 0;
    check("cancel_state", int'(state), 6);
    check("cancel_count", int'(phase_count), 0);
    n = 0; cr_seen = int'(coin_ret);
    while (!done && n < 30) begin step(); n++; cr_seen |= int'(coin_ret); end
    check("cancel_done_after", n, 10);
    check("cancel_no_coin", cr_seen, 0);

    // Motor failure in RINSE pass 1, then fault clear handling.
    start_run();
    run_until(5, 3, 1, 100);
    mf = 1; step(); mf = 0;
    check("mf_state", int'(state), 7);
    check("mf_fault", int'(fault), 1);
    fc = 1; step();
    check("mf_clear_lid_closed", int'(state), 7);
    lid = 0; step();
    check("mf_clear_state", int'(state), 0);
    check("mf_clear_coin", int'(coin_ret), 1);
    fc = 0; lid = 1; step();
    check("mf_coin_pulse_end", int'(coin_ret), 0);

    // Out-of-balance: ignored in WASH, pauses SPIN.
    start_run();
    run_until(4, 2, 0, 100);
    oob = 1; step();
    check("oob_wash_count", int'(phase_count), 3);
    check("oob_wash_paused", int'(paused), 0);
    oob = 0;
    run_until(6, 4, 0, 100);
    oob = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("oob_spin_paused", int'(paused), 1);
      check("oob_spin_count", int'(phase_count), 4);
    end
    oob = 0; step();
    check("oob_spin_resume", int'(phase_count), 5);

    // Synchronous reset mid-RINSE.
    start_run();
    run_until(5, 5, 1, 100);
    reset = 1; step(); reset = 0;
    check("rst_state", int'(state), 0);
    check("rst_count", int'(phase_count), 0);
    check("rst_rinse", int'(rinse_index), 0);
    check("rst_outputs", int'({paused, water, fault, coin_ret, done}), 0);

    // Randomized stimulus against the model.
    idle_inputs(); reset = 1; step();
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 399) == 0);
      lid    = ($urandom_range(0, 9) != 0);
      coin   = ($urandom_range(0, 2) == 0);
      cancel = ($urandom_range(0, 39) == 0);
      oob    = ($urandom_range(0, 4) == 0);
      mf     = ($urandom_range(0, 59) == 0);
      fc     = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/wm_cycle_sequencer.md
Name: wm_cycle_sequencer

Overview:
- Parametrised next-generation washing-machine sequencer that merges phase timing and control into one block.
- Phase durations are programmable by parameter, and the rinse phase repeats a configurable number of times.
- Lid-open and out-of-balance conditions pause the phase timer instead of aborting the cycle.
- Motor failure enters a latched FAULT state, left only by an explicit clear; the block sits directly under the microcontroller top level.

Parameters:
- CNT_W, 16, width of phase cycle counter.
- FILL_CYCLES, 8, clocks spent in FILL (>=1, < 2**CNT_W).
- HEAT_CYCLES, 8, clocks spent in HEAT (>=1).
- WASH_CYCLES, 16, clocks spent in WASH (>=1).
- RINSE_CYCLES, 12, clocks per rinse pass (>=1).
- SPIN_CYCLES, 10, clocks spent in SPIN (>=1).
- NUM_RINSE, 2, number of rinse passes (1..2**RINSE_W-1).
- RINSE_W, 4, width of rinse pass index.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- sig_Lid_Closed  in  1  level; 1 = lid closed.
- sig_Coin  in  1  level; coin accepted.
- sig_Cancel  in  1  level; user cancel.
- sig_Out_Of_Balance  in  1  level; drum unbalanced.
- sig_Motor_Failure  in  1  level; motor fault.
- sig_Fault_Clear  in  1  level; operator fault acknowledge.
- state  out  3  encoded FSM state.
- phase_Count  out  CNT_W  current phase elapsed clocks.
- rinse_Index  out  RINSE_W  current rinse pass, 0-based.
- paused  out  1  timer held this cycle.
- water_Intake  out  1  high in FILL and not paused.
- fault  out  1  high in FAULT.
- coin_Return  out  1  one-clock pulse.
- cycle_Done  out  1  one-clock pulse on normal completion.

Behaviour:
- State encoding: IDLE=0, READY=1, FILL=2, HEAT=3, WASH=4, RINSE=5, SPIN=6, FAULT=7. The encoding is shared with other blocks through the package.
- Reset (synchronous, active-high): state=IDLE; phase_Count=0; rinse_Index=0. All pulse and level outputs are 0. Reset overrides every other input, including mid-cycle.
- All outputs are registered. A transition takes effect on the clock edge after its condition is sampled, so latency is 1 clock.
- IDLE: sig_Coin=1 -> READY. All other inputs are ignored.
- READY:
  - sig_Cancel=1 -> IDLE with coin_Return pulse.
  - Otherwise sig_Lid_Closed=1 -> FILL, phase_Count=0.
  - Cancel has priority over lid.
- Running states are FILL, HEAT, WASH, RINSE and SPIN. Per-clock priority, highest first:
  1. sig_Motor_Failure=1 in WASH, RINSE or SPIN -> FAULT, phase_Count=0.
  2. sig_Cancel=1 in FILL, HEAT, WASH or RINSE -> SPIN (drain spin), phase_Count=0, rinse_Index=0, no coin return. Cancel in SPIN is ignored.
  3. Pause condition: sig_Lid_Closed=0, or sig_Out_Of_Balance=1 while in SPIN. Effect: paused=1 and phase_Count holds.
  4. Otherwise, if phase_Count == DURATION-1, advance to the next phase with phase_Count=0. Else phase_Count increments by 1.
- Phase advance order:
  - FILL -> HEAT.
  - HEAT -> WASH.
  - WASH -> RINSE with rinse_Index=0.
  - RINSE end: if rinse_Index == NUM_RINSE-1 -> SPIN with rinse_Index=0. Else rinse_Index+1 and stay in RINSE with phase_Count=0.
  - SPIN end -> IDLE with a cycle_Done pulse.
- Timing: with no pauses, the phase with duration D occupies exactly D clocks. The total from FILL entry to cycle_Done is FILL+HEAT+WASH+NUM_RINSE*RINSE+SPIN clocks.
- Counter arithmetic:
  - Unsigned, compared by equality, so it never wraps.
  - Parameters are checked at elaboration: durations >=1 and fit in CNT_W; NUM_RINSE >=1 and fits in RINSE_W.
- FAULT:
  - fault=1, phase_Count=0.
  - sig_Fault_Clear=1 with sig_Lid_Closed=0 -> IDLE with coin_Return pulse.
  - Fault clear while the lid is closed is ignored.
  - sig_Motor_Failure still high when clear is sampled -> stay in FAULT.
- Pulse outputs (coin_Return, cycle_Done) are high for exactly one clock.
- paused is 0 outside running states.
- A sig_Coin received in any state other than IDLE is ignored.

Decomposition:
- Shared package wm_pkg holds:
  - the 3-bit state typedef and its constants (IDLE..FAULT);
  - default duration constants;
  - the function mapping a state to its phase duration.
- One natural sub-module, wm_phase_timer:
  - contains the counter with hold, clear and terminal-count compare;
  - takes the current duration as input and outputs phase_Count and phase_End.
- FSM and output logic stay in the top module.

Test Plan:
- Normal run (defaults): coin, then lid closed held. Required: FILL 8, HEAT 8, WASH 16, RINSE 12 with rinse_Index 0, RINSE 12 with rinse_Index 1, SPIN 10 clocks. Then cycle_Done pulses once 66 clocks after FILL entry, and state returns to 0.
- Lid-open pause: open the lid for 5 clocks at WASH phase_Count=7. Required: paused=1, phase_Count holds at 7, state stays 4. WASH ends 5 clocks later than in the normal run.
- Cancel paths:
  - cancel in READY -> coin_Return pulses 1 clock, state=0;
  - cancel in HEAT -> state=6 with phase_Count=0, cycle_Done after 10 clocks, no coin_Return.
- Motor failure: assert at RINSE pass 1, count 3. Required: state=7 and fault=1 next clock. Clear with lid closed is ignored. Clear with lid open gives state=0 and a coin_Return pulse.
- Out-of-balance in SPIN: assert for 4 clocks. Required: paused=1 and phase_Count frozen. Asserting it in WASH has no effect.
- Synchronous reset mid-RINSE: assert reset at any count. Required: next clock state=0, phase_Count=0, rinse_Index=0, all outputs 0.
